qar_alarm_sched: RTL

Alarm scheduler that multiplexes `N_ALARMS` software alarms onto compare channel 0 of the timer. It sits between the CPU bus and the timer, owning a dedicated bus-master port into the timer register file. It keeps absolute deadlines, programs the timer's CMP0 with the nearest armed deadline, and polls the compare-hit status. It then marks expired alarms and raises an interrupt.

---
 rtl/qar_timer_pkg.sv | 38 +++
 rtl/qar_alarm_minsel.sv | 53 +++++
 rtl/qar_alarm_sched.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/qar_timer_pkg.sv
// Shared definitions for the alarm scheduler and its timer-side interface.
//   - timer register word addresses (COUNTER, STATUS, CMP0)
//   - scheduler slave register word addresses
//   - scheduler FSM state encoding
//   - wrap_ge(): modular "a is at or after b" test used for all deadline math
package qar_timer_pkg;

    localparam logic [5:0] TMR_COUNTER_WORD = 6'h2;
    localparam logic [5:0] TMR_STATUS_WORD  = 6'h3;
    localparam logic [5:0] TMR_CMP_WORD     = 6'h5;

    localparam logic [5:0] REG_CTRL    = 6'd0;
    localparam logic [5:0] REG_EXPIRED = 6'd1;
    localparam logic [5:0] REG_IRQ_EN  = 6'd2;
    localparam logic [5:0] REG_ARMED   = 6'd3;
    localparam logic [5:0] REG_ACTIVE  = 6'd4;
    localparam logic [5:0] REG_DL_BASE = 6'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CNT,
        ST_SCAN,
        ST_WR_CMP,
        ST_CLR,
        ST_VERIFY,
        ST_WAIT,
        ST_DIS
    } sched_state_t;

    // True when a is at or past b on the 32-bit modular timeline
    // (valid while the two lie within 2^31 ticks of each other).
    function automatic logic wrap_ge(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] diff;
        diff = a - b;
        return ~diff[31];
    endfunction

endpackage

// File: rtl/qar_alarm_minsel.sv
// Sequential minimum-distance tracker. Cleared by start, then fed one
// candidate slot per cycle; keeps the slot with the smallest distance.
// Slots arrive in ascending index order and only a strictly smaller distance
// replaces the current best, so ties resolve to the lowest index.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start                       forget the current best
//   slot_valid/idx/dl/dist      candidate presented this cycle
//   best_valid/idx/dl           current winner
module qar_alarm_minsel #(
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             slot_valid,
    input  logic [IDX_W-1:0] slot_idx,
    input  logic [31:0]      slot_dl,
    input  logic [31:0]      slot_dist,
    output logic             best_valid,
    output logic [IDX_W-1:0] best_idx,
    output logic [31:0]      best_dl
);

    logic             best_valid_reg;
    logic [IDX_W-1:0] best_idx_reg;
    logic [31:0]      best_dl_reg;
    logic [31:0]      best_dist_reg;
    logic             take;

    assign take = slot_valid && (!best_valid_reg || (slot_dist < best_dist_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_valid_reg <= 1'b0;
            best_idx_reg   <= '0;
            best_dl_reg    <= '0;
            best_dist_reg  <= '0;
        end else if (start) begin
            best_valid_reg <= 1'b0;
        end else if (take) begin
            best_valid_reg <= 1'b1;
            best_idx_reg   <= slot_idx;
            best_dl_reg    <= slot_dl;
            best_dist_reg  <= slot_dist;
        end
    end

    assign best_valid = best_valid_reg;
    assign best_idx   = best_idx_reg;
    assign best_dl    = best_dl_reg;

endmodule

// File: rtl/qar_alarm_sched.sv
// Alarm scheduler: multiplexes N_ALARMS software alarms onto timer CMP0.
// Keeps absolute deadlines, programs CMP0 with the nearest armed one, polls
// the timer compare-hit status, marks expired alarms and raises irq.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   bus_write/bus_read/addr_word/wdata/rdata   CPU slave port
//   tmr_write/tmr_read/tmr_addr_word/tmr_wdata/tmr_rdata   master port into timer
//   irq                               |(expired & irq_en)
module qar_alarm_sched #(
    parameter int unsigned N_ALARMS         = 4,
    parameter logic [5:0]  TMR_COUNTER_ADDR = qar_timer_pkg::TMR_COUNTER_WORD,
    parameter logic [5:0]  TMR_STATUS_ADDR  = qar_timer_pkg::TMR_STATUS_WORD,
    parameter logic [5:0]  TMR_CMP_ADDR     = qar_timer_pkg::TMR_CMP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [5:0]  addr_word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tmr_write,
    output logic        tmr_read,
    output logic [5:0]  tmr_addr_word,
    output logic [31:0] tmr_wdata,
    input  logic [31:0] tmr_rdata,
    output logic        irq
);
    import qar_timer_pkg::*;

    localparam int unsigned IDX_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    sched_state_t         state_reg, state_next;
    logic                 enable_reg;
    logic [N_ALARMS-1:0]  expired_reg, expired_next;
    logic [N_ALARMS-1:0]  irq_en_reg;
    logic [N_ALARMS-1:0]  armed_reg, armed_next;
    logic [2:0]           active_idx_reg;
    logic                 active_valid_reg;
    logic                 resched_reg, resched_next;
    logic [31:0]          dl_reg [N_ALARMS];
    logic [IDX_W-1:0]     scan_idx_reg;
    logic [31:0]          now_reg;

    // Slave decode
    logic wr_ctrl, wr_expired, wr_irq_en, wr_armed;
    logic [N_ALARMS-1:0] dl_sel, dl_wr, scan_expire_vec;

    assign wr_ctrl    = bus_write && (addr_word == REG_CTRL);
    assign wr_expired = bus_write && (addr_word == REG_EXPIRED);
    assign wr_irq_en  = bus_write && (addr_word == REG_IRQ_EN);
    assign wr_armed   = bus_write && (addr_word == REG_ARMED);

    // Scan of the slot selected by scan_idx_reg
    logic [31:0] scan_dl, scan_dist;
    logic        scan_hit, scan_expire, scan_cand;

    assign scan_dl   = dl_reg[scan_idx_reg];
    assign scan_dist = scan_dl - now_reg;
    // A CPU write to the slot being scanned takes precedence: the stale
    // deadline neither expires nor competes, and the write forces a rescan.
    assign scan_hit    = (state_reg == ST_SCAN) && armed_reg[scan_idx_reg] && !dl_wr[scan_idx_reg];
    assign scan_expire = scan_hit && wrap_ge(now_reg, scan_dl);
    assign scan_cand   = scan_hit && !wrap_ge(now_reg, scan_dl);

    for (genvar gi = 0; gi < N_ALARMS; gi++) begin : g_slot
        localparam logic [5:0] DL_ADDR = 6'(REG_DL_BASE + gi);
        assign dl_sel[gi]          = (addr_word == DL_ADDR);
        assign dl_wr[gi]           = bus_write && dl_sel[gi];
        assign scan_expire_vec[gi] = scan_expire && (scan_idx_reg == IDX_W'(gi));
        assign armed_next[gi]      = dl_wr[gi] ||
                                     (armed_reg[gi] && !scan_expire_vec[gi] && !(wr_armed && wdata[gi]));
        // Expiry set wins over a simultaneous W1C.
        assign expired_next[gi]    = scan_expire_vec[gi] ||
                                     (expired_reg[gi] && !(wr_expired && wdata[gi]));
    end

    // Min-distance tracker
    logic             best_valid;
    logic [IDX_W-1:0] best_idx;
    logic [31:0]      best_dl;

    qar_alarm_minsel #(.IDX_W(IDX_W)) u_minsel (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (state_reg == ST_RD_CNT),
        .slot_valid (scan_cand),
        .slot_idx   (scan_idx_reg),
        .slot_dl    (scan_dl),
        .slot_dist  (scan_dist),
        .best_valid (best_valid),
        .best_idx   (best_idx),
        .best_dl    (best_dl)
    );

    // Deadline missed while CMP0 was being programmed: $signed(counter-best) > 0
    logic [31:0] verify_diff;
    logic        verify_late;
    assign verify_diff = tmr_rdata - best_dl;
    assign verify_late = !verify_diff[31] && (verify_diff != 32'd0);

    always_comb begin
        state_next    = state_reg;
        tmr_write     = 1'b0;
        tmr_read      = 1'b0;
        tmr_addr_word = 6'd0;
        tmr_wdata     = 32'd0;
        case (state_reg)
            ST_IDLE: begin
                if (enable_reg && resched_reg) state_next = ST_RD_CNT;
            end
            ST_RD_CNT: begin
                tmr_read      = 1'b1;
                tmr_addr_word = TMR_COUNTER_ADDR;
                state_next    = ST_SCAN;
            end
            ST_SCAN: begin
                if (scan_idx_reg == IDX_W'(N_ALARMS - 1))
                    state_next = (best_valid || scan_cand) ? ST_WR_CMP : ST_DIS;
            end
            ST_WR_CMP: begin
                tmr_write     = 1'b1;
                tmr_addr_word = TMR_CMP_ADDR;
                tmr_wdata     = best_dl;
                state_next    = ST_CLR;
            end
            ST_CLR: begin
                tmr_write     = 1'b1;
                tmr_addr_word = TMR_STATUS_ADDR;
                tmr_wdata     = 32'd1;
                state_next    = ST_VERIFY;
            end
            ST_VERIFY: begin
                tmr_read      = 1'b1;
                tmr_addr_word = TMR_COUNTER_ADDR;
                state_next    = verify_late ? ST_RD_CNT : ST_WAIT;
            end
            ST_WAIT: begin
                tmr_read      = 1'b1;
                tmr_addr_word = TMR_STATUS_ADDR;
                if (tmr_rdata[0] || resched_reg) state_next = ST_RD_CNT;
            end
            ST_DIS: begin
                tmr_write     = 1'b1;
                tmr_addr_word = TMR_CMP_ADDR;
                tmr_wdata     = 32'd0;
                state_next    = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Disabling overrides any sequence in flight; this cycle's bus op still issues.
        if (!enable_reg && (state_reg != ST_IDLE) && (state_reg != ST_DIS))
            state_next = ST_DIS;
    end

    // A new request arriving on the same edge we start a scan is kept, so it
    // cannot be lost; at worst it costs one extra rescan.
    assign resched_next = (|dl_wr) || wr_armed || (wr_ctrl && wdata[0] && !enable_reg) ||
                          (resched_reg && (state_next != ST_RD_CNT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            enable_reg       <= 1'b0;
            expired_reg      <= '0;
            irq_en_reg       <= '0;
            armed_reg        <= '0;
            active_idx_reg   <= 3'd0;
            active_valid_reg <= 1'b0;
            resched_reg      <= 1'b0;
            scan_idx_reg     <= '0;
            now_reg          <= 32'd0;
            for (int i = 0; i < N_ALARMS; i++) dl_reg[i] <= 32'd0;
        end else begin
            state_reg   <= state_next;
            expired_reg <= expired_next;
            armed_reg   <= armed_next;
            resched_reg <= resched_next;
            if (wr_ctrl)   enable_reg <= wdata[0];
            if (wr_irq_en) irq_en_reg <= wdata[N_ALARMS-1:0];
            // CMP0 == 0 disables the timer compare, so a zero deadline becomes 1.
            for (int i = 0; i < N_ALARMS; i++)
                if (dl_wr[i]) dl_reg[i] <= (wdata == 32'd0) ? 32'd1 : wdata;
            if (state_reg == ST_RD_CNT) begin
                now_reg      <= tmr_rdata;
                scan_idx_reg <= '0;
            end else if (state_reg == ST_SCAN) begin
                scan_idx_reg <= scan_idx_reg + 1'b1;
            end
            if (state_reg == ST_WR_CMP) begin
                active_idx_reg   <= 3'(best_idx);
                active_valid_reg <= 1'b1;
            end else if (state_reg == ST_DIS) begin
                active_valid_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (bus_read) begin
            case (addr_word)
                REG_CTRL:    rdata = {31'd0, enable_reg};
                REG_EXPIRED: rdata = 32'(expired_reg);
                REG_IRQ_EN:  rdata = 32'(irq_en_reg);
                REG_ARMED:   rdata = 32'(armed_reg);
                REG_ACTIVE:  rdata = {23'd0, active_valid_reg, 5'd0, active_idx_reg};
                default: begin
                    for (int i = 0; i < N_ALARMS; i++)
                        if (dl_sel[i]) rdata = dl_reg[i];
                end
            endcase
        end
    end

    assign irq = |(expired_reg & irq_en_reg);

endmodule
